// File: rtl/lsu_mem_access.sv
// Memory-stage load/store unit: single-outstanding req/ack bus, lane steering, load extension.
// Latency 3 cycles with immediate ack (+1 per wait cycle); stalls upstream while a transfer is in flight.
module lsu_mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  inst_size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mreq,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            lat_write;
    logic [1:0]      lat_size;
    logic            lat_uns;
    logic [1:0]      lat_a;

    logic            req;
    logic            start;
    logic            expired;
    logic [3:0]      be_nxt;
    logic [31:0]     wdata_nxt;
    logic [31:0]     shifted;
    logic [31:0]     ext;

    assign req        = mem_read | mem_write;
    assign misaligned = (state == IDLE) & req &
                        (((inst_size == 2'b01) & addr[0]) | (inst_size[1] & (addr[1:0] != 2'b00)));
    assign start      = (state == IDLE) & req & ~misaligned;
    // Reset gating keeps stall low even if decode still presents the abandoned request.
    assign stall      = ~reset & (start | (state == REQ));
    assign expired    = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        case (inst_size)
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = bus_rdata >> {lat_a, 3'b000};
        ext     = bus_rdata;
        case (lat_size)
            2'b00:   ext = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
            default: ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (bus_ack || expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mreq       <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= 32'h0;
            bus_be     <= 4'h0;
            bus_wdata  <= 32'h0;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_a      <= 2'b00;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mreq      <= 1'b1;
                    bus_write <= mem_write;
                    bus_addr  <= {addr[31:2], 2'b00};
                    bus_be    <= be_nxt;
                    bus_wdata <= wdata_nxt;
                    cnt       <= '0;
                    lat_write <= mem_write;
                    lat_size  <= inst_size;
                    lat_uns   <= load_unsigned;
                    lat_a     <= addr[1:0];
                end
                REQ: if (bus_ack) begin
                    mreq <= 1'b0;
                    if (!lat_write) begin
                        load_data  <= ext;
                        load_valid <= 1'b1;
                    end
                end else if (expired) begin
                    mreq       <= 1'b0;
                    bus_err    <= 1'b1;
                    load_data  <= 32'h0;
                    load_valid <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    load_valid <= 1'b0;
                    bus_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_access.sv
// Table-driven bench for lsu_mem_access with a load-result scoreboard queue.
module tb_lsu_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, load_unsigned;
    logic [1:0]  inst_size;
    logic [31:0] addr, store_data, bus_rdata;
    logic        bus_ack;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic        load_valid, stall, misaligned, bus_err, mreq, bus_write;
    logic [3:0]  bus_be;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_dly;   // REQ cycles before ack; negative = never
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ldata;
        logic        err;
    } vec_t;

    vec_t tbl[13];

    lsu_mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .inst_size(inst_size), .load_unsigned(load_unsigned), .addr(addr),
        .store_data(store_data), .load_data(load_data), .load_valid(load_valid),
        .stall(stall), .misaligned(misaligned), .bus_err(bus_err), .mreq(mreq),
        .bus_write(bus_write), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int  stall_cnt, mreq_cnt, exp_mreq;
        bit  done;
        logic exp_lv;
        mem_read = v.rd; mem_write = v.wr; inst_size = v.size; load_unsigned = v.uns;
        addr = v.addr; store_data = v.sdata; bus_ack = 1'b0;
        exp_lv = v.rd & ~v.wr & ~v.err;
        if (exp_lv) sb_q.push_back(v.ldata);
        #1;
        check("misaligned_ok", 32'(misaligned), 32'd0);
        check("stall_req_cycle", 32'(stall), 32'd1);
        stall_cnt = 1; mreq_cnt = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            if (stall) begin
                stall_cnt++;
                if (mreq) begin
                    mreq_cnt++;
                    if (mreq_cnt == 1) begin
                        check("bus_write", 32'(bus_write), 32'(v.wr));
                        check("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
                        check("bus_be", 32'(bus_be), 32'(v.be));
                        if (v.wr) check("bus_wdata", bus_wdata, v.wdata);
                    end
                    bus_ack = (mreq_cnt == v.ack_dly + 1);
                    bus_rdata = v.rdata;
                end
            end else begin
                done = 1;
                check("mreq_done", 32'(mreq), 32'd0);
                check("bus_err_done", 32'(bus_err), 32'(v.err));
                check("load_valid_done", 32'(load_valid), 32'(exp_lv));
                if (load_valid) begin
                    if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                    else check("load_data", load_data, sb_q.pop_front());
                end
                if (v.err) check("load_data_err", load_data, 32'h0);
                mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
            end
        end
        if (!done) begin
            check("transfer_done", 32'd0, 32'd1);
            mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        end
        exp_mreq = (v.ack_dly < 0) ? 16 : v.ack_dly + 1;
        check("mreq_cycles", 32'(mreq_cnt), 32'(exp_mreq));
        check("stall_cycles", 32'(stall_cnt), 32'(exp_mreq + 1));
        @(posedge clk); #1;
        check("idle_load_valid", 32'(load_valid), 32'd0);
        check("idle_bus_err", 32'(bus_err), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        //          rd  wr  size  uns addr          sdata         rdata         dly be       wdata         ldata         err
        tbl[0]  = '{0, 1, 2'b00, 0, 32'h0000_1003, 32'h1234_56AB, 32'h0,        0, 4'b1000, 32'hABAB_ABAB, 32'h0,        0};
        tbl[1]  = '{1, 0, 2'b00, 0, 32'h0000_2001, 32'h0,        32'h1234_80FF, 0, 4'b0010, 32'h0,        32'hFFFF_FF80, 0};
        tbl[2]  = '{1, 0, 2'b00, 1, 32'h0000_2001, 32'h0,        32'h1234_80FF, 0, 4'b0010, 32'h0,        32'h0000_0080, 0};
        tbl[3]  = '{1, 0, 2'b01, 0, 32'h0000_3002, 32'h0,        32'h8001_7FFF, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 0};
        tbl[4]  = '{1, 0, 2'b10, 0, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 3, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0};
        tbl[5]  = '{1, 0, 2'b10, 0, 32'h0000_4000, 32'h0,        32'h5555_5555, -1, 4'b1111, 32'h0,       32'h0,        1};
        tbl[6]  = '{0, 1, 2'b01, 0, 32'h0000_5002, 32'h0000_CAFE, 32'h0,        1, 4'b1100, 32'hCAFE_CAFE, 32'h0,        0};
        tbl[7]  = '{1, 0, 2'b01, 1, 32'h0000_6000, 32'h0,        32'h1234_F00D, 0, 4'b0011, 32'h0,        32'h0000_F00D, 0};
        tbl[8]  = '{1, 0, 2'b00, 0, 32'h0000_7000, 32'h0,        32'h0000_007F, 2, 4'b0001, 32'h0,        32'h0000_007F, 0};
        tbl[9]  = '{0, 1, 2'b11, 0, 32'h0000_8000, 32'h0102_0304, 32'h0,        0, 4'b1111, 32'h0102_0304, 32'h0,        0};
        tbl[10] = '{1, 0, 2'b10, 1, 32'h0000_8004, 32'h0,        32'h8000_0000, 0, 4'b1111, 32'h0,        32'h8000_0000, 0};
        tbl[11] = '{1, 1, 2'b00, 0, 32'h0000_9000, 32'h0000_0011, 32'h0,        0, 4'b0001, 32'h1111_1111, 32'h0,        0};
        tbl[12] = '{1, 0, 2'b00, 0, 32'h0000_A003, 32'h0,        32'hC300_0000, 1, 4'b1000, 32'h0,        32'hFFFF_FFC3, 0};

        reset = 1'b1; mem_read = 0; mem_write = 0; inst_size = 2'b00; load_unsigned = 0;
        addr = 0; store_data = 0; bus_rdata = 0; bus_ack = 0;
        #1;
        check("rst_mreq", 32'(mreq), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_bus_write", 32'(bus_write), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // Misaligned half and word: no stall, no bus request.
        mem_read = 1; inst_size = 2'b01; addr = 32'h0000_3001;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mis_half_flag", 32'(misaligned), 32'd1);
            check("mis_half_stall", 32'(stall), 32'd0);
            check("mis_half_mreq", 32'(mreq), 32'd0);
            @(posedge clk); #1;
        end
        inst_size = 2'b10; addr = 32'h0000_4002; #1;
        check("mis_word_flag", 32'(misaligned), 32'd1);
        check("mis_word_stall", 32'(stall), 32'd0);
        mem_read = 0; #1;
        check("mis_clear", 32'(misaligned), 32'd0);
        @(posedge clk); #1;
        check("mis_no_mreq", 32'(mreq), 32'd0);

        // Stray ack in IDLE is ignored.
        bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("stray_ack_mreq", 32'(mreq), 32'd0);
        check("stray_ack_lv", 32'(load_valid), 32'd0);
        bus_ack = 0;
        @(posedge clk); #1;

        // Reset during REQ abandons the transfer immediately.
        mem_read = 1; inst_size = 2'b10; addr = 32'h0000_B000;
        @(posedge clk); #1;
        check("pre_rst_mreq", 32'(mreq), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_mreq", 32'(mreq), 32'd0);
        check("async_rst_stall", 32'(stall), 32'd0);
        mem_read = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_mreq", 32'(mreq), 32'd0);
        run_vec(tbl[4]);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
